// File: rtl/gat_pkg.sv
// Shared widths, record layouts and FSM encoding for the sparse-H row scheduler.
// Widths are sized for the full dataset; smaller builds use the low bits.
package gat_pkg;

  localparam int G_DATA_W      = 8;
  localparam int G_COL_IDX_W   = $clog2(1433);
  localparam int G_NUM_NODE_W  = $clog2(168);
  localparam int G_ROW_IDX_W   = $clog2(13264);
  localparam int G_H_DATA_W    = G_DATA_W + G_COL_IDX_W;
  localparam int G_NODE_INFO_W = G_COL_IDX_W + G_NUM_NODE_W + 1;

  typedef struct packed {
    logic [G_COL_IDX_W-1:0]  row_len;
    logic [G_NUM_NODE_W-1:0] num_node;
    logic                    flag;
  } node_info_t;

  typedef struct packed {
    logic [G_H_DATA_W-1:0]   data;
    logic [G_ROW_IDX_W-1:0]  row_idx;
    logic [G_NUM_NODE_W-1:0] num_node;
    logic                    flag;
    logic                    row_last;
    logic                    row_empty;
  } h_beat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INFO_RD,
    S_INFO_LAT,
    S_DATA,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/h_row_fifo.sv
// Small synchronous FIFO of tagged H beats; head is read straight from the storage flops.
// Caller guarantees no push when full and no pop when empty.
module h_row_fifo
  import gat_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  h_beat_t       push_dat_i,
  input  logic          pop_i,
  output h_beat_t       head_o,
  output logic          vld_o,
  output logic [AW:0]   count_o
);

  h_beat_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign vld_o   = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/h_row_scheduler.sv
// Walks node_info row by row, fetches each row's sparse H entries and streams them out
// tagged with row metadata; reads are credit-checked so the output FIFO never overflows.
module h_row_scheduler
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_FEATURE_IN    = 1433,
  parameter int TOTAL_NODES       = 13264,
  parameter int H_NUM_SPARSE_DATA = 242101,
  parameter int MAX_NODES         = 168,
  parameter int FIFO_DEPTH        = 4,
  localparam int COL_IDX_WIDTH    = $clog2(NUM_FEATURE_IN),
  localparam int NODE_INFO_ADDR_W = $clog2(TOTAL_NODES),
  localparam int H_DATA_ADDR_W    = $clog2(H_NUM_SPARSE_DATA),
  localparam int NUM_NODE_WIDTH   = $clog2(MAX_NODES),
  localparam int H_DATA_WIDTH     = DATA_WIDTH + COL_IDX_WIDTH,
  localparam int NODE_INFO_WIDTH  = COL_IDX_WIDTH + NUM_NODE_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        h_vld_i,
  output logic                        h_rdy_o,
  output logic [NODE_INFO_ADDR_W-1:0] node_info_bram_addrb,
  input  logic [NODE_INFO_WIDTH-1:0]  node_info_bram_dout,
  output logic [H_DATA_ADDR_W-1:0]    h_data_bram_addrb,
  input  logic [H_DATA_WIDTH-1:0]     h_data_bram_dout,
  output logic                        out_vld_o,
  input  logic                        out_rdy_i,
  output logic [H_DATA_WIDTH-1:0]     out_data_o,
  output logic [NODE_INFO_ADDR_W-1:0] out_row_idx_o,
  output logic [NUM_NODE_WIDTH-1:0]   out_num_node_o,
  output logic                        out_flag_o,
  output logic                        out_row_last_o,
  output logic                        out_row_empty_o,
  output logic                        done_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  state_t                      state_q;
  logic [NODE_INFO_ADDR_W-1:0] row_q;
  logic [H_DATA_ADDR_W-1:0]    data_ptr_q;
  logic [H_DATA_ADDR_W-1:0]    h_addr_q;
  logic [G_COL_IDX_W-1:0]      remaining_q;
  logic [G_NUM_NODE_W-1:0]     num_node_q;
  logic                        flag_q;
  logic                        row_empty_q;
  logic                        inflight_q;
  logic                        h_rdy_q;
  logic                        done_q;
  h_beat_t                     pend_q;

  node_info_t                  info;
  h_beat_t                     push_beat;
  h_beat_t                     head;
  logic [CNT_W-1:0]            fifo_cnt;
  logic [CNT_W:0]              credit_used;
  logic                        fifo_vld;
  logic                        pop;
  logic                        issue;
  logic                        rd_en;
  logic                        row_done;
  logic                        last_row;

  assign info = node_info_t'(node_info_bram_dout);

  // A beat issued last cycle still owns a FIFO slot until it lands.
  always_comb begin
    credit_used = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
    issue       = (state_q == S_DATA) && (credit_used < DEPTH_C);
    rd_en       = issue && !row_empty_q;
    row_done    = issue && (row_empty_q || (remaining_q == G_COL_IDX_W'(1)));
    last_row    = (row_q == NODE_INFO_ADDR_W'(TOTAL_NODES - 1));
    push_beat   = pend_q;
    if (!pend_q.row_empty) push_beat.data = h_data_bram_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      data_ptr_q  <= '0;
      h_addr_q    <= '0;
      remaining_q <= '0;
      num_node_q  <= '0;
      flag_q      <= 1'b0;
      row_empty_q <= 1'b0;
      inflight_q  <= 1'b0;
      h_rdy_q     <= 1'b1;
      done_q      <= 1'b0;
      pend_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        pend_q.data      <= '0;
        pend_q.row_idx   <= G_ROW_IDX_W'(row_q);
        pend_q.num_node  <= num_node_q;
        pend_q.flag      <= flag_q;
        pend_q.row_last  <= row_done;
        pend_q.row_empty <= row_empty_q;
      end
      if (rd_en) begin
        h_addr_q    <= data_ptr_q;
        data_ptr_q  <= data_ptr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (h_vld_i) begin
            state_q    <= S_INFO_RD;
            row_q      <= '0;
            data_ptr_q <= '0;
            h_rdy_q    <= 1'b0;
          end
        end
        S_INFO_RD:  state_q <= S_INFO_LAT;
        S_INFO_LAT: begin
          remaining_q <= info.row_len;
          num_node_q  <= info.num_node;
          flag_q      <= info.flag;
          row_empty_q <= (info.row_len == '0);
          state_q     <= S_DATA;
        end
        S_DATA: begin
          if (row_done) begin
            if (last_row) begin
              state_q <= S_DRAIN;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= S_INFO_RD;
            end
          end
        end
        S_DRAIN: begin
          if ((fifo_cnt == '0) && !inflight_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          h_rdy_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  h_row_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_dat_i (push_beat),
    .pop_i      (pop),
    .head_o     (head),
    .vld_o      (fifo_vld),
    .count_o    (fifo_cnt)
  );

  assign pop                  = fifo_vld & out_rdy_i;
  assign h_rdy_o              = h_rdy_q;
  assign done_o               = done_q;
  assign node_info_bram_addrb = row_q;
  // Hold the last issued address when idle so the port never shows the post-increment pointer.
  assign h_data_bram_addrb    = rd_en ? data_ptr_q : h_addr_q;
  assign out_vld_o            = fifo_vld;
  assign out_data_o           = head.data;
  assign out_row_idx_o        = NODE_INFO_ADDR_W'(head.row_idx);
  assign out_num_node_o       = head.num_node;
  assign out_flag_o           = head.flag;
  assign out_row_last_o       = head.row_last;
  assign out_row_empty_o      = head.row_empty;

endmodule

// File: tb/tb_h_row_scheduler.sv
// Directed bench for h_row_scheduler with three node_info rows and behavioural BRAMs.
module tb_h_row_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_vld_i = 1'b0;
  logic        out_rdy_i = 1'b1;
  logic        h_rdy_o, out_vld_o, out_flag_o, out_row_last_o, out_row_empty_o, done_o;
  logic [1:0]  ni_addr;
  logic [19:0] ni_dout;
  logic [17:0] h_addr;
  logic [18:0] h_dout;
  logic [18:0] out_data_o;
  logic [1:0]  out_row_idx_o;
  logic [7:0]  out_num_node_o;

  always #5 clk = ~clk;

  h_row_scheduler #(.TOTAL_NODES(3)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .h_vld_i              (h_vld_i),
    .h_rdy_o              (h_rdy_o),
    .node_info_bram_addrb (ni_addr),
    .node_info_bram_dout  (ni_dout),
    .h_data_bram_addrb    (h_addr),
    .h_data_bram_dout     (h_dout),
    .out_vld_o            (out_vld_o),
    .out_rdy_i            (out_rdy_i),
    .out_data_o           (out_data_o),
    .out_row_idx_o        (out_row_idx_o),
    .out_num_node_o       (out_num_node_o),
    .out_flag_o           (out_flag_o),
    .out_row_last_o       (out_row_last_o),
    .out_row_empty_o      (out_row_empty_o),
    .done_o               (done_o)
  );

  logic [19:0] ni_mem [0:2];
  logic [18:0] h_mem  [0:15];

  always @(posedge clk) begin
    ni_dout <= (ni_addr < 2'd3) ? ni_mem[ni_addr] : 20'd0;
    h_dout  <= (h_addr < 18'd16) ? h_mem[h_addr[3:0]] : 19'd0;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  bit clr_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects accepted beats, done pulses, latency, address range, stall stability.
  logic [18:0] q_data [$];
  logic [1:0]  q_row [$];
  logic        q_last [$];
  logic        q_empty [$];
  logic [7:0]  q_nn [$];
  logic        q_flag [$];
  int          done_cnt = 0;
  int          first_vld_cyc = -1;
  int          max_addr = 0;
  int          stall_viol = 0;
  bit          prev_stall = 1'b0;
  logic [18:0] p_data;
  logic [1:0]  p_row;
  logic        p_last, p_empty;

  always @(negedge clk) begin
    if (clr_req) begin
      q_data.delete(); q_row.delete(); q_last.delete();
      q_empty.delete(); q_nn.delete(); q_flag.delete();
      done_cnt = 0; first_vld_cyc = -1; max_addr = 0; stall_viol = 0; prev_stall = 1'b0;
    end else begin
      if (done_o) done_cnt++;
      if (out_vld_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (int'(h_addr) > max_addr) max_addr = int'(h_addr);
      if (prev_stall && (!out_vld_o || out_data_o !== p_data || out_row_idx_o !== p_row ||
                         out_row_last_o !== p_last || out_row_empty_o !== p_empty))
        stall_viol++;
      prev_stall = out_vld_o && !out_rdy_i;
      p_data = out_data_o; p_row = out_row_idx_o; p_last = out_row_last_o; p_empty = out_row_empty_o;
      if (out_vld_o && out_rdy_i) begin
        q_data.push_back(out_data_o); q_row.push_back(out_row_idx_o);
        q_last.push_back(out_row_last_o); q_empty.push_back(out_row_empty_o);
        q_nn.push_back(out_num_node_o); q_flag.push_back(out_flag_o);
      end
    end
  end

  task automatic clear_mon();
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic set_rows(input int l0, input int l1, input int l2);
    ni_mem[0] = {11'(l0), 8'd10, 1'b0};
    ni_mem[1] = {11'(l1), 8'd11, 1'b1};
    ni_mem[2] = {11'(l2), 8'd12, 1'b0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; h_vld_i = 1'b0; out_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 h_vld_i = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    h_vld_i = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (h_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_h_rdy got=%b want=1", h_rdy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
    total++; if (out_vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", out_vld_o); end
    total++; if (ni_addr !== 2'd0 || h_addr !== 18'd0) begin
      bad++; $display("FAIL reset_addr got ni=%0d h=%0d want 0 0", ni_addr, h_addr); end
    total++; if ({out_data_o, out_row_idx_o, out_num_node_o, out_flag_o, out_row_last_o, out_row_empty_o} !== 32'd0) begin
      bad++; $display("FAIL reset_outs got data=%h row=%0d nn=%0d f=%b l=%b e=%b want all 0",
                      out_data_o, out_row_idx_o, out_num_node_o, out_flag_o, out_row_last_o, out_row_empty_o); end
  endtask

  task automatic test_basic();
    int er[6] = '{0, 0, 1, 1, 1, 2};
    bit el[6] = '{0, 1, 0, 0, 1, 1};
    bit ok;
    do_reset(); set_rows(2, 3, 1); clear_mon();
    start_pulse();
    wait_done(1, 200, ok);
    repeat (3) @(posedge clk);
    #1;
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout got no done want done"); end
    total++; if (q_data.size() != 6) begin bad++; $display("FAIL basic_count got=%0d want=6", q_data.size()); end
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      total++;
      if (q_data[k] !== h_mem[k] || q_row[k] !== 2'(er[k]) || q_last[k] !== el[k] || q_empty[k] !== 1'b0 ||
          q_nn[k] !== 8'(10 + er[k]) || q_flag[k] !== 1'(er[k] % 2)) begin
        bad++; $display("FAIL basic_beat%0d got d=%h r=%0d l=%b e=%b nn=%0d f=%b want d=%h r=%0d l=%b e=0 nn=%0d f=%0d",
                        k, q_data[k], q_row[k], q_last[k], q_empty[k], q_nn[k], q_flag[k],
                        h_mem[k], er[k], el[k], 10 + er[k], er[k] % 2);
      end
    end
    total++; if (first_vld_cyc != t0 + 4) begin
      bad++; $display("FAIL basic_latency got=%0d want=%0d", first_vld_cyc - t0, 4); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    total++; if (h_rdy_o !== 1'b1) begin bad++; $display("FAIL basic_rdy_back got=%b want=1", h_rdy_o); end
  endtask

  task automatic test_random_stall();
    int er[6] = '{0, 0, 1, 1, 1, 2};
    bit el[6] = '{0, 1, 0, 0, 1, 1};
    bit ok = 1'b0;
    do_reset(); set_rows(2, 3, 1); clear_mon();
    out_rdy_i = ($urandom_range(0, 9) < 3);
    start_pulse();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 out_rdy_i = ($urandom_range(0, 9) < 3);
      if (done_cnt >= 1) begin ok = 1'b1; break; end
    end
    out_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (!ok) begin bad++; $display("FAIL rstall_timeout got no done want done"); end
    total++; if (q_data.size() != 6) begin bad++; $display("FAIL rstall_count got=%0d want=6", q_data.size()); end
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      total++;
      if (q_data[k] !== h_mem[k] || q_row[k] !== 2'(er[k]) || q_last[k] !== el[k]) begin
        bad++; $display("FAIL rstall_beat%0d got d=%h r=%0d l=%b want d=%h r=%0d l=%b",
                        k, q_data[k], q_row[k], q_last[k], h_mem[k], er[k], el[k]);
      end
    end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL rstall_stable got=%0d changes want=0", stall_viol); end
    total++; if (max_addr > 5) begin bad++; $display("FAIL rstall_max_addr got=%0d want<=5", max_addr); end
  endtask

  task automatic test_stall_fill();
    int er[6] = '{0, 0, 1, 1, 1, 2};
    bit ok;
    do_reset(); set_rows(2, 3, 1); clear_mon();
    out_rdy_i = 1'b0;
    start_pulse();
    repeat (20) @(posedge clk);
    #1;
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL fill_popped got=%0d want=0", q_data.size()); end
    total++; if (out_vld_o !== 1'b1 || out_data_o !== h_mem[0] || out_row_idx_o !== 2'd0) begin
      bad++; $display("FAIL fill_head got v=%b d=%h r=%0d want v=1 d=%h r=0", out_vld_o, out_data_o, out_row_idx_o, h_mem[0]); end
    total++; if (max_addr != 3 || h_addr !== 18'd3) begin
      bad++; $display("FAIL fill_reads got max=%0d addr=%0d want 3 3", max_addr, h_addr); end
    out_rdy_i = 1'b1;
    wait_done(1, 200, ok);
    #1;
    total++; if (!ok || q_data.size() != 6) begin
      bad++; $display("FAIL fill_release got ok=%b n=%0d want ok=1 n=6", ok, q_data.size()); end
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      total++;
      if (q_data[k] !== h_mem[k] || q_row[k] !== 2'(er[k])) begin
        bad++; $display("FAIL fill_beat%0d got d=%h r=%0d want d=%h r=%0d", k, q_data[k], q_row[k], h_mem[k], er[k]);
      end
    end
  endtask

  task automatic test_empty_rows();
    int er[4] = '{0, 1, 1, 2};
    bit el[4] = '{1, 0, 1, 1};
    bit ee[4] = '{1, 0, 0, 1};
    logic [18:0] ed[4];
    bit ok;
    ed[0] = 19'd0; ed[1] = h_mem[0]; ed[2] = h_mem[1]; ed[3] = 19'd0;
    do_reset(); set_rows(0, 2, 0); clear_mon();
    start_pulse();
    wait_done(1, 200, ok);
    repeat (2) @(posedge clk);
    #1;
    total++; if (!ok || q_data.size() != 4) begin
      bad++; $display("FAIL empty_count got ok=%b n=%0d want ok=1 n=4", ok, q_data.size()); end
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      total++;
      if (q_data[k] !== ed[k] || q_row[k] !== 2'(er[k]) || q_last[k] !== el[k] || q_empty[k] !== ee[k]) begin
        bad++; $display("FAIL empty_beat%0d got d=%h r=%0d l=%b e=%b want d=%h r=%0d l=%b e=%b",
                        k, q_data[k], q_row[k], q_last[k], q_empty[k], ed[k], er[k], el[k], ee[k]);
      end
    end
    total++; if (max_addr != 1) begin bad++; $display("FAIL empty_max_addr got=%0d want=1", max_addr); end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    do_reset(); set_rows(2, 3, 1); clear_mon();
    start_pulse();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (out_vld_o && out_row_idx_o == 2'd1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rmid_reach_row1 got none want row1 beat"); end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    total++; if (out_vld_o !== 1'b0 || h_rdy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL rmid_after got v=%b rdy=%b done=%b want 0 1 0", out_vld_o, h_rdy_o, done_o); end
    total++; if (ni_addr !== 2'd0 || h_addr !== 18'd0) begin
      bad++; $display("FAIL rmid_addr got ni=%0d h=%0d want 0 0", ni_addr, h_addr); end
    repeat (10) @(posedge clk);
    #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", done_cnt); end
    clear_mon();
    start_pulse();
    wait_done(1, 200, ok);
    #1;
    total++; if (!ok || q_data.size() != 6) begin
      bad++; $display("FAIL rmid_replay_count got ok=%b n=%0d want ok=1 n=6", ok, q_data.size()); end
    for (int k = 0; k < 6 && k < q_data.size(); k++) begin
      total++;
      if (q_data[k] !== h_mem[k]) begin
        bad++; $display("FAIL rmid_replay_beat%0d got=%h want=%h", k, q_data[k], h_mem[k]);
      end
    end
  endtask

  task automatic test_hold_vld();
    bit ok = 1'b0;
    do_reset(); set_rows(2, 3, 1); clear_mon();
    @(posedge clk);
    #1 h_vld_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL hold_first_done got none want pulse"); end
    @(posedge clk);
    #1;
    total++; if (h_rdy_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL hold_idle got rdy=%b done=%b want 1 0", h_rdy_o, done_o); end
    @(posedge clk);
    #1;
    total++; if (h_rdy_o !== 1'b0) begin bad++; $display("FAIL hold_restart got rdy=%b want 0", h_rdy_o); end
    wait_done(2, 200, ok);
    h_vld_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (!ok || done_cnt != 2) begin
      bad++; $display("FAIL hold_two_passes got ok=%b done=%0d want ok=1 done=2", ok, done_cnt); end
    total++; if (q_data.size() != 12) begin bad++; $display("FAIL hold_count got=%0d want=12", q_data.size()); end
    for (int k = 0; k < 12 && k < q_data.size(); k++) begin
      total++;
      if (q_data[k] !== h_mem[k % 6]) begin
        bad++; $display("FAIL hold_beat%0d got=%h want=%h", k, q_data[k], h_mem[k % 6]);
      end
    end
    total++; if (h_rdy_o !== 1'b1) begin bad++; $display("FAIL hold_final_rdy got=%b want=1", h_rdy_o); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) h_mem[i] = {8'(i * 7 + 3), 11'(i * 13 + 1)};
    set_rows(2, 3, 1);
    test_reset();
    test_basic();
    test_random_stall();
    test_stall_fill();
    test_empty_rows();
    test_reset_mid();
    test_hold_vld();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
